// File: rtl/pio_bank_pkg.sv
// Shared constants for the pio_bank GPIO component: register offsets within a
// channel's 8-word window, the edge-type encoding and the bus data width.
package pio_bank_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OFF_OUT     = 3'd0;
  localparam logic [2:0] OFF_IN      = 3'd1;
  localparam logic [2:0] OFF_SET     = 3'd2;
  localparam logic [2:0] OFF_CLR     = 3'd3;
  localparam logic [2:0] OFF_TOGGLE  = 3'd4;
  localparam logic [2:0] OFF_MASK    = 3'd5;
  localparam logic [2:0] OFF_EDGECAP = 3'd6;
  localparam logic [2:0] OFF_RSVD    = 3'd7;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_channel.sv
// One GPIO channel: output register with atomic set/clear/toggle, interrupt
// mask, input synchroniser, edge detector and write-1-to-clear edge capture.
module pio_channel
  import pio_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             edgeEn_i,
  input  logic             we_i,
  input  logic [2:0]       offset_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] mask_o,
  output logic [WIDTH-1:0] cap_o,
  output logic [WIDTH-1:0] inSync_o,
  output logic             irqReq_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] edges;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      int'(EDGE_RISE): edges = sync_q[SYNC_STAGES-1] & ~prev_q;
      int'(EDGE_FALL): edges = ~sync_q[SYNC_STAGES-1] & prev_q;
      default:         edges = sync_q[SYNC_STAGES-1] ^ prev_q;
    endcase
  end

  // A fresh edge is OR-ed in after the W1C so that a same-cycle set wins.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    if (we_i) begin
      case (offset_i)
        OFF_OUT:     out_d  = wdata_i;
        OFF_SET:     out_d  = out_q | wdata_i;
        OFF_CLR:     out_d  = out_q & ~wdata_i;
        OFF_TOGGLE:  out_d  = out_q ^ wdata_i;
        OFF_MASK:    mask_d = wdata_i;
        OFF_EDGECAP: cap_d  = cap_q & ~wdata_i;
        default:     ;
      endcase
    end
    if (edgeEn_i) cap_d = cap_d | edges;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= RESET_VALUE;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  assign out_o    = out_q;
  assign mask_o   = mask_q;
  assign cap_o    = cap_q;
  assign inSync_o = sync_q[SYNC_STAGES-1];
  assign irqReq_o = |(cap_q & mask_q);

endmodule

// File: rtl/pio_bank.sv
// Avalon-MM GPIO bank: CHANNELS pio_channel instances behind an 8-word-per-channel
// address map, fixed one-cycle read latency and a registered level interrupt.
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CHANNELS    = 2,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [$clog2(CHANNELS)+2:0] avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [31:0]                 avs_writedata,
  output logic [31:0]                 avs_readdata,
  output logic                        avs_readdatavalid,
  input  logic [CHANNELS*WIDTH-1:0]   pio_in_export,
  output logic [CHANNELS*WIDTH-1:0]   pio_out_export,
  output logic                        irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] SUPPRESS = CNT_W'(SYNC_STAGES + 1);

  int               chSel;
  logic [2:0]       offset;
  logic [CNT_W-1:0] edgeCnt_q;
  logic             edgeEn;
  logic [WIDTH-1:0] chOut  [CHANNELS];
  logic [WIDTH-1:0] chMask [CHANNELS];
  logic [WIDTH-1:0] chCap  [CHANNELS];
  logic [WIDTH-1:0] chIn   [CHANNELS];
  logic [CHANNELS-1:0] chIrq;
  logic [WIDTH-1:0] chVal;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic             rvalid_q;
  logic             irq_q;
  logic             unusedWdata;

  assign chSel       = 32'(avs_address >> 3);
  assign offset      = avs_address[2:0];
  assign unusedWdata = ^avs_writedata;

  // Synchronisers restart from zero, so hold off capture until they have filled.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) edgeCnt_q <= '0;
    else if (!edgeEn) edgeCnt_q <= edgeCnt_q + CNT_W'(1);
  end
  assign edgeEn = (edgeCnt_q == SUPPRESS);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    pio_channel #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE),
      .RESET_VALUE(RESET_VALUE)
    ) u_ch (
      .clk_i   (clk_clk),
      .rst_i   (reset_reset),
      .edgeEn_i(edgeEn),
      .we_i    (avs_write && (chSel == ch)),
      .offset_i(offset),
      .wdata_i (avs_writedata[WIDTH-1:0]),
      .pin_i   (pio_in_export[ch*WIDTH +: WIDTH]),
      .out_o   (chOut[ch]),
      .mask_o  (chMask[ch]),
      .cap_o   (chCap[ch]),
      .inSync_o(chIn[ch]),
      .irqReq_o(chIrq[ch])
    );
    assign pio_out_export[ch*WIDTH +: WIDTH] = chOut[ch];
  end

  // Unmatched channel indices and write-only offsets fall through to zero.
  always_comb begin
    chVal = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chSel == i) begin
        case (offset)
          OFF_OUT:     chVal = chOut[i];
          OFF_IN:      chVal = chIn[i];
          OFF_MASK:    chVal = chMask[i];
          OFF_EDGECAP: chVal = chCap[i];
          default:     chVal = '0;
        endcase
      end
    end
    rdata_d = DATA_W'(chVal);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= avs_read;
      if (avs_read) rdata_q <= rdata_d;
      irq_q <= |chIrq;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_pio_bank.sv
// Bench for pio_bank: a two-channel instance checked through a read scoreboard
// plus a three-channel instance for addresses beyond the populated channels.
module tb_pio_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [3:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [15:0] pinIn = '0;
  logic [15:0] pinOut;
  logic        irq;

  logic [4:0]  addr3 = '0;
  logic        rd3 = 1'b0;
  logic        wr3 = 1'b0;
  logic [31:0] wdata3 = '0;
  logic [31:0] rdata3;
  logic        rvalid3;
  logic [23:0] pinIn3 = '0;
  logic [23:0] pinOut3;
  logic        irq3;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expQ[$];
  logic        expValid = 1'b0;
  logic [31:0] expData;

  pio_bank #(
    .WIDTH(8), .CHANNELS(2), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(8'hA5)
  ) dut (
    .clk_clk          (clk),
    .reset_reset      (reset),
    .avs_address      (addr),
    .avs_read         (rd),
    .avs_write        (wr),
    .avs_writedata    (wdata),
    .avs_readdata     (rdata),
    .avs_readdatavalid(rvalid),
    .pio_in_export    (pinIn),
    .pio_out_export   (pinOut),
    .irq              (irq)
  );

  pio_bank #(
    .WIDTH(8), .CHANNELS(3), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(8'h5A)
  ) dut3 (
    .clk_clk          (clk),
    .reset_reset      (reset),
    .avs_address      (addr3),
    .avs_read         (rd3),
    .avs_write        (wr3),
    .avs_writedata    (wdata3),
    .avs_readdata     (rdata3),
    .avs_readdatavalid(rvalid3),
    .pio_in_export    (pinIn3),
    .pio_out_export   (pinOut3),
    .irq              (irq3)
  );

  always #5 clk = ~clk;

  // Valid is expected exactly one cycle after every read not killed by reset.
  always @(posedge clk) expValid <= reset ? 1'b0 : rd;

  // Scoreboard: each read pushes its expected data, popped when valid is due.
  always @(negedge clk) begin
    total++;
    if (rvalid !== expValid) begin
      bad++;
      $display("[TB] FAIL readdatavalid: got %b want %b at %0t", rvalid, expValid, $time);
    end
    if (expValid && expQ.size() > 0) begin
      expData = expQ.pop_front();
      total++;
      if (rvalid !== 1'b1 || rdata !== expData) begin
        bad++;
        $display("[TB] FAIL readdata: got %h want %h at %0t", rdata, expData, $time);
      end
    end
  end

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, input logic [31:0] e);
    addr = a; rd = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (pinOut !== 16'hA5A5) begin bad++; $display("[TB] FAIL reset_out: got %h want a5a5", pinOut); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    reset = 1'b0;
    busRead(4'd0, 32'h000000A5);
    busRead(4'd5, 32'h0);
    busRead(4'd6, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_set_clr_toggle();
    logic [2:0] offs [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [7:0] data [4] = '{8'h0F, 8'hF0, 8'h03, 8'h81};
    logic [7:0] exps [4] = '{8'h0F, 8'hFF, 8'hFC, 8'h7D};
    for (int i = 0; i < 4; i++) begin
      busWrite({1'b1, offs[i]}, {24'h0, data[i]});
      total++;
      if (pinOut[15:8] !== exps[i]) begin
        bad++; $display("[TB] FAIL ch1_out step %0d: got %h want %h", i, pinOut[15:8], exps[i]);
      end
      total++;
      if (pinOut[7:0] !== 8'hA5) begin
        bad++; $display("[TB] FAIL ch0_untouched step %0d: got %h want a5", i, pinOut[7:0]);
      end
    end
    busRead(4'd8, 32'h7D);
    busRead(4'd10, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_edge_irq();
    busWrite(4'd5, 32'h01);
    pinIn[0] = 1'b1;
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL edge_irq_t: got %b want 0", irq); end
    busRead(4'd1, 32'h00);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL edge_irq_t1: got %b want 0", irq); end
    busRead(4'd1, 32'h01);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL edge_irq_t2: got %b want 0", irq); end
    busRead(4'd6, 32'h01);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL edge_irq_t3: got %b want 1", irq); end
    busWrite(4'd6, 32'h01);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL w1c_irq_same: got %b want 1", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL w1c_irq_next: got %b want 0", irq); end
  endtask

  task automatic test_w1c_race();
    pinIn[0] = 1'b0;
    repeat (4) @(negedge clk);
    pinIn[0] = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL race_setup_irq: got %b want 1", irq); end
    pinIn[0] = 1'b0;
    repeat (4) @(negedge clk);
    pinIn[0] = 1'b1;
    repeat (2) @(negedge clk);
    busWrite(4'd6, 32'h01);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL race_irq_a: got %b want 1", irq); end
    busRead(4'd6, 32'h01);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL race_irq_b: got %b want 1", irq); end
    busWrite(4'd6, 32'h01);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL race_clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_unmasked();
    pinIn[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (irq !== 1'b0) begin bad++; $display("[TB] FAIL unmasked_irq %0d: got %b want 0", i, irq); end
    end
    busRead(4'd6, 32'h08);
    busWrite(4'd5, 32'h08);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL mask_irq_same: got %b want 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL mask_irq_next: got %b want 1", irq); end
    busRead(4'd5, 32'h08);
  endtask

  task automatic test_simul_rw();
    addr = 4'd0; wdata = 32'h3C; rd = 1'b1; wr = 1'b1;
    expQ.push_back(32'hA5);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    total++;
    if (pinOut[7:0] !== 8'h3C) begin bad++; $display("[TB] FAIL simul_out: got %h want 3c", pinOut[7:0]); end
    busRead(4'd0, 32'h3C);
  endtask

  task automatic test_back_to_back();
    busRead(4'd8, 32'h7D);
    busRead(4'd0, 32'h3C);
    busRead(4'd13, 32'h00);
    busRead(4'd7, 32'h00);
    busRead(4'd9, 32'h00);
    busRead(4'd1, 32'h09);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    addr = 4'd0; rd = 1'b1; reset = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    total++;
    if (pinOut !== 16'hA5A5) begin bad++; $display("[TB] FAIL rst2_out: got %h want a5a5", pinOut); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst2_irq: got %b want 0", irq); end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    busRead(4'd6, 32'h00);
    busRead(4'd1, 32'h09);
    busWrite(4'd5, 32'h09);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL suppress_irq: got %b want 0", irq); end
  endtask

  task automatic test_out_of_range();
    addr3 = 5'b10000; rd3 = 1'b1;
    @(negedge clk);
    rd3 = 1'b0;
    total++;
    if (rvalid3 !== 1'b1 || rdata3 !== 32'h5A) begin
      bad++; $display("[TB] FAIL ch2_read: got %b/%h want 1/0000005a", rvalid3, rdata3);
    end
    addr3 = 5'b11000; rd3 = 1'b1;
    @(negedge clk);
    rd3 = 1'b0;
    total++;
    if (rvalid3 !== 1'b1 || rdata3 !== 32'h0) begin
      bad++; $display("[TB] FAIL oor_read: got %b/%h want 1/00000000", rvalid3, rdata3);
    end
    addr3 = 5'b11000; wdata3 = 32'hFF; wr3 = 1'b1;
    @(negedge clk);
    addr3 = 5'b11010;
    @(negedge clk);
    wr3 = 1'b0;
    total++;
    if (pinOut3 !== 24'h5A5A5A) begin bad++; $display("[TB] FAIL oor_write: got %h want 5a5a5a", pinOut3); end
    total++;
    if (rvalid3 !== 1'b0) begin bad++; $display("[TB] FAIL oor_idle_valid: got %b want 0", rvalid3); end
  endtask

  initial begin
    test_reset();
    test_set_clr_toggle();
    test_edge_irq();
    test_w1c_race();
    test_unmasked();
    test_simul_rw();
    test_back_to_back();
    test_reset_mid_read();
    test_out_of_range();
    @(negedge clk);
    total++;
    if (expQ.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", expQ.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
